// File: rtl/multi_channel_iir_filter.sv
// Time-multiplexed first-order IIR stage: one shared datapath serves CH channels.
// Each channel selects low-pass, high-pass, bypass or hold and has its own state and overflow flag.
module multi_channel_iir_filter #(
    parameter int CH   = 2,
    parameter int IW   = 14,
    parameter int FRAC = 6,
    parameter int KW   = 4,
    parameter int KMAX = 15
) (
    input  logic                     qzt_clk,
    input  logic                     reset_n,
    input  logic                     sample_strobe,
    input  logic [CH*IW-1:0]         vin,
    input  logic [CH*KW-1:0]         k,
    input  logic [CH*2-1:0]          mode,
    output logic [CH*(IW+FRAC)-1:0]  vout,
    output logic                     out_valid,
    output logic                     busy,
    output logic [CH-1:0]            overflow,
    output logic                     missed
);

    localparam int AW   = IW + FRAC;
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int KLIM = (KMAX < (1 << KW) - 1) ? KMAX : (1 << KW) - 1;
    localparam logic [KW-1:0] KMAX_K  = KLIM[KW-1:0];
    localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CALC    = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;

    localparam logic [1:0] M_LP   = 2'b00;
    localparam logic [1:0] M_HP   = 2'b01;
    localparam logic [1:0] M_BYP  = 2'b10;

    // Clip an AW+1 bit result into the AW-bit output range.
    function automatic logic signed [AW-1:0] sat_aw(input logic signed [AW:0] v);
        logic signed [AW-1:0] r;
        if (v[AW] != v[AW-1]) begin
            r = v[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            r = v[AW-1:0];
        end
        return r;
    endfunction

    function automatic logic clipped(input logic signed [AW:0] v);
        return v[AW] ^ v[AW-1];
    endfunction

    logic [1:0]              state_q, state_d;
    logic                    strobe_q;
    logic [CW-1:0]           ch_idx_q, ch_idx_d;
    logic [CH*IW-1:0]        vin_q, vin_d;
    logic [CH*KW-1:0]        k_q, k_d;
    logic [CH*2-1:0]         mode_q, mode_d;
    logic signed [AW-1:0]    y_q [CH];
    logic signed [AW-1:0]    y_d [CH];
    logic signed [AW-1:0]    shadow_q [CH];
    logic signed [AW-1:0]    shadow_d [CH];
    logic [CH*AW-1:0]        vout_q, vout_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic [CH-1:0]           overflow_q, overflow_d;
    logic                    missed_q, missed_d;

    logic                    strobe_edge;
    logic [IW-1:0]           vin_cur;
    logic [KW-1:0]           k_cur;
    logic [KW-1:0]           ks_c;
    logic [1:0]              mode_cur;
    logic signed [AW-1:0]    x_c;
    logic signed [AW-1:0]    y_c;
    logic signed [AW:0]      d_c;
    logic signed [AW:0]      step_c;
    logic signed [AW:0]      ynew_w;
    logic signed [AW-1:0]    ynew_c;
    logic signed [AW:0]      hp_c;

    assign strobe_edge = sample_strobe & ~strobe_q;

    assign vin_cur  = vin_q[ch_idx_q*IW +: IW];
    assign k_cur    = k_q[ch_idx_q*KW +: KW];
    assign mode_cur = mode_q[ch_idx_q*2 +: 2];
    assign ks_c     = (k_cur > KMAX_K) ? KMAX_K : k_cur;

    // |d >>> ks| never exceeds |x - y|, so y + step stays inside the AW range.
    always_comb begin
        x_c    = {vin_cur, {FRAC{1'b0}}};
        y_c    = y_q[ch_idx_q];
        d_c    = $signed({x_c[AW-1], x_c}) - $signed({y_c[AW-1], y_c});
        step_c = d_c >>> ks_c;
        ynew_w = $signed({y_c[AW-1], y_c}) + step_c;
        ynew_c = ynew_w[AW-1:0];
        hp_c   = $signed({x_c[AW-1], x_c}) - $signed({ynew_c[AW-1], ynew_c});
    end

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        vin_d       = vin_q;
        k_d         = k_q;
        mode_d      = mode_q;
        y_d         = y_q;
        shadow_d    = shadow_q;
        vout_d      = vout_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        overflow_d  = overflow_q;
        missed_d    = missed_q;

        case (state_q)
            ST_IDLE: begin
                if (strobe_edge) begin
                    vin_d    = vin;
                    k_d      = k;
                    mode_d   = mode;
                    ch_idx_d = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                case (mode_cur)
                    M_LP: begin
                        y_d[ch_idx_q]      = ynew_c;
                        shadow_d[ch_idx_q] = ynew_c;
                    end
                    M_HP: begin
                        y_d[ch_idx_q]      = ynew_c;
                        shadow_d[ch_idx_q] = sat_aw(hp_c);
                        if (clipped(hp_c)) begin
                            overflow_d[ch_idx_q] = 1'b1;
                        end
                    end
                    M_BYP: begin
                        y_d[ch_idx_q]      = x_c;
                        shadow_d[ch_idx_q] = x_c;
                    end
                    default: begin
                    end
                endcase
                if (ch_idx_q == LAST_CH) begin
                    state_d = ST_PUBLISH;
                end else begin
                    ch_idx_d = ch_idx_q + 1'b1;
                end
            end
            ST_PUBLISH: begin
                for (int i = 0; i < CH; i++) begin
                    vout_d[i*AW +: AW] = shadow_q[i];
                end
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An edge outside IDLE is dropped; only the sticky flag records it.
        if (strobe_edge && (state_q != ST_IDLE)) begin
            missed_d = 1'b1;
        end
    end

    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            strobe_q    <= 1'b0;
            ch_idx_q    <= '0;
            vin_q       <= '0;
            k_q         <= '0;
            mode_q      <= '0;
            vout_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= '0;
            missed_q    <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                y_q[i]      <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            strobe_q    <= sample_strobe;
            ch_idx_q    <= ch_idx_d;
            vin_q       <= vin_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            vout_q      <= vout_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            missed_q    <= missed_d;
            for (int i = 0; i < CH; i++) begin
                y_q[i]      <= y_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign vout      = vout_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign missed    = missed_q;

endmodule
